// File: rtl/clock_display_pkg.sv
// Shared definitions for the HH:MM:SS multiplexed 7-segment display.
// Holds the digit count, active-high segment codes ({g,f,e,d,c,b,a}),
// the digit index type, field limits and a binary-to-BCD helper.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [2:0] digit_idx_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Splits a 0..63 binary value into {tens, ones}. Tens never exceeds 6.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/clock_display_seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Ports:
//   bcd_i   - BCD digit 0..9
//   dash_i  - show a dash (segment g only) instead of the digit
//   blank_i - show nothing; overrides dash_i and bcd_i
//   seg_o   - segment pattern {g,f,e,d,c,b,a}, 1 = lit
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dash_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: every path assigns seg_o (default first), so no latch is inferred.
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (dash_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display.sv
// Six-digit multiplexed 7-segment driver for HH MM SS.
// Takes a snapshot of sec/min/hr/set_mode once per scan frame (on the last
// slot of digit 5), so each frame shows one coherent time, then scans one
// digit per SCAN_DIV clocks. Hour and minute digits blink in set mode; the
// colon (dp on digits 2 and 4) is shown only outside set mode.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   sec, min  - binary 0..59 (larger values display as dashes)
//   hr        - binary 0..23 (larger values display as dashes)
//   set_mode  - 1 = clock being set, enables blinking
//   seg, dp   - segments {g,f,e,d,c,b,a} and decimal point, registered
//   an        - one-hot digit enable, bit i = digit i, registered
// Polarity of seg/dp/an follows SEG_ACTIVE_LOW.
module clock_display
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       set_mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // XOR masks apply output polarity; the reset values are the "off" levels.
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [5:0] AN_POL  = {6{SEG_ACTIVE_LOW}};

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  digit_idx_t         digit_q, digit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [5:0]         sec_q, min_q;
  logic [4:0]         hr_q;
  logic               set_mode_q;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [5:0]         an_q, an_d;

  logic       scan_tick;
  logic       snap;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       sec_bad, min_bad, hr_bad;
  logic [3:0] dig_bcd;
  logic       dig_dash, dig_blank, dp_on;
  logic [6:0] seg_raw;

  assign scan_tick = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign snap      = scan_tick && (digit_q == LAST_DIGIT);

  // Counter and blink next-state.
  always_comb begin
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;

    digit_d = digit_q;
    if (scan_tick) begin
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
    end

    // Outside set mode the blink state sits at zero, so entering set mode
    // always starts with a full visible half-period.
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (set_mode_q) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end
  end

  assign sec_bcd = bin_to_bcd(sec_q);
  assign min_bcd = bin_to_bcd(min_q);
  assign hr_bcd  = bin_to_bcd({1'b0, hr_q});
  assign sec_bad = (sec_q > 6'(SEC_MAX));
  assign min_bad = (min_q > 6'(MIN_MAX));
  assign hr_bad  = (hr_q > 5'(HR_MAX));

  // Select the BCD digit and decorations for the digit being scanned.
  always_comb begin
    dig_bcd  = 4'd0;
    dig_dash = 1'b0;
    case (digit_q)
      3'd0:    begin dig_bcd = sec_bcd[3:0]; dig_dash = sec_bad; end
      3'd1:    begin dig_bcd = sec_bcd[7:4]; dig_dash = sec_bad; end
      3'd2:    begin dig_bcd = min_bcd[3:0]; dig_dash = min_bad; end
      3'd3:    begin dig_bcd = min_bcd[7:4]; dig_dash = min_bad; end
      3'd4:    begin dig_bcd = hr_bcd[3:0];  dig_dash = hr_bad;  end
      3'd5:    begin dig_bcd = hr_bcd[7:4];  dig_dash = hr_bad;  end
      default: begin dig_bcd = 4'd0;         dig_dash = 1'b0;    end
    endcase
    // Gating with set_mode_q keeps a stale phase from blanking the first
    // clock after leaving set mode.
    dig_blank = set_mode_q && blink_phase_q && (digit_q >= 3'd2);
    dp_on     = !set_mode_q && ((digit_q == 3'd2) || (digit_q == 3'd4));
  end

  seg7_decode u_decode (
    .bcd_i   (dig_bcd),
    .dash_i  (dig_dash),
    .blank_i (dig_blank),
    .seg_o   (seg_raw)
  );

  assign seg_d = seg_raw ^ SEG_POL;
  assign dp_d  = dp_on ^ SEG_ACTIVE_LOW;
  assign an_d  = (6'b1 << digit_q) ^ AN_POL;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset sits in the sensitivity list so outputs blank the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sec_q         <= '0;
      min_q         <= '0;
      hr_q          <= '0;
      set_mode_q    <= 1'b0;
      seg_q         <= SEG_POL;
      dp_q          <= SEG_ACTIVE_LOW;
      an_q          <= AN_POL;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (snap) begin
        sec_q      <= sec;
        min_q      <= min;
        hr_q       <= hr;
        set_mode_q <= set_mode;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with SCAN_DIV=4, BLINK_DIV=8, active-low
// outputs. Edge k is the k-th rising edge after reset release; after edge k
// the scanned digit is ((k-1)/4)%6, and in set mode the blink half-period
// counted from the snapshot edge decides whether digits 2..5 are blank.
module tb_clock_display;

  logic       clk;
  logic       rst;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       set_mode;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_vec;
  int n_err;
  int k;
  int blink_base;
  logic       exp_set;
  logic [6:0] exp_code [6];

  clock_display #(
    .SCAN_DIV       (4),
    .BLINK_DIV      (8),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .set_mode (set_mode),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic set_exp(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                         input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
    exp_code[0] = d0; exp_code[1] = d1; exp_code[2] = d2;
    exp_code[3] = d3; exp_code[4] = d4; exp_code[5] = d5;
  endtask

  // Runs n clocks, checking an/seg/dp after each rising edge.
  task automatic run_check(input int n);
    int         idx;
    logic       blank;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      idx   = ((k - 1) / 4) % 6;
      blank = exp_set && (idx >= 2) && ((((k - blink_base - 1) / 8) % 2) == 1);
      e_an  = ~(6'b1 << idx);
      e_seg = blank ? 7'h7F : ~exp_code[idx];
      e_dp  = ~(!exp_set && ((idx == 2) || (idx == 4)));
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, 32'(an), 32'h3F);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; k = 0; blink_base = 0; exp_set = 1'b0;
    sec = 6'd0; min = 6'd0; hr = 5'd0; set_mode = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_off("reset");

    // Release; 2 frames of 00:00:00 with colon.
    rst = 1'b0;
    k = 0;
    set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    run_check(48);

    // 23:45:07: one frame of the old snapshot, then the new time.
    hr = 5'd23; min = 6'd45; sec = 6'd7;
    run_check(24);
    set_exp(7'h07, 7'h3F, 7'h6D, 7'h66, 7'h4F, 7'h5B);
    run_check(24);

    // Inputs change while digit 2 is shown; this frame keeps the old time.
    run_check(8);
    sec = 6'd38; min = 6'd12;
    run_check(16);
    set_exp(7'h7F, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B);
    run_check(24);

    // Out-of-range sec and hr show dashes; min stays correct.
    sec = 6'd60; min = 6'd59; hr = 5'd24;
    run_check(24);
    set_exp(7'h40, 7'h40, 7'h6F, 7'h6D, 7'h40, 7'h40);
    run_check(24);

    // Set mode at 12:34:56: hour/minute digits blink with 8-clock halves.
    sec = 6'd56; min = 6'd34; hr = 5'd12; set_mode = 1'b1;
    run_check(24);
    set_exp(7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    exp_set    = 1'b1;
    blink_base = k;
    run_check(48);

    // Reset while digit 3 is being scanned.
    run_check(13);
    check("digit3_before_rst", 32'(an), 32'h37);
    rst = 1'b1;
    #1;
    check_off("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_off("rst_held");
    set_mode = 1'b0;
    rst = 1'b0;
    k = 0;
    exp_set = 1'b0;
    set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    run_check(24);
    set_exp(7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    run_check(24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
